mmio_uart_tx: RTL

Memory-mapped UART transmitter that sits on the CPU data-memory bus beside `dmem` as a bus responder. The CPU stores bytes to a data register. The block buffers them in a small FIFO and serialises them LSB-first on `tx` as 8N1 frames, at a programmable clocks-per-bit rate. Status and divisor registers are readable through the same combinational read path the CPU uses for `dmem`.

---
 rtl/mmio_uart_tx.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped UART transmitter on the CPU data-memory bus.
//               Bytes stored to TXDATA are queued in a small FIFO and sent
//               LSB-first as 8N1 frames (8E1 when UART_TX_PARITY_EN is
//               defined) at a programmable clocks-per-bit rate.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk      - single clock, rising edge
//   reset_n  - asynchronous active-low reset
//   sel      - address decode hit; the bus is ignored when low
//   we       - store strobe
//   memsize  - access size (unused; byte lane 0 only)
//   a        - byte offset, a[3:2] selects the register
//   wd       - store data
//   rd       - combinational read data (0 when sel is low)
//   tx       - serial line, idles high
// Register map (a[3:2]):
//   0 TXDATA  write pushes wd[7:0], reads 0
//   1 STATUS  {28'b0, ovf, busy, empty, full}; any write clears ovf
//   2 DIV     {16'b0, div}
//   3 reserved
// Configuration macro: UART_TX_PARITY_EN (adds an even-parity bit)
// ============================================================================
module mmio_uart_tx #(
    parameter int          FIFO_AW   = 3,
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sel,
    input  logic        we,
    input  logic [2:0]  memsize,
    input  logic [3:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        tx
);

    localparam logic [FIFO_AW:0] c_depth = {1'b1, {FIFO_AW{1'b0}}};

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_start  = 3'd1;
    localparam logic [2:0] c_data   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_parity = 3'd3;
`endif
    localparam logic [2:0] c_stop   = 3'd4;

    logic [2:0]         r_state;
    logic [15:0]        r_timer;
    logic [2:0]         r_bitcnt;
    logic [7:0]         r_shreg;
    logic [15:0]        r_div;
    logic               r_ovf;
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [7:0]         r_mem [0:(1<<FIFO_AW)-1];
`ifdef UART_TX_PARITY_EN
    logic               r_par;
`endif

    logic        w_full;
    logic        w_empty;
    logic        w_busy;
    logic        w_bit_end;
    logic        w_pop;
    logic        w_wr;
    logic        w_push_req;
    logic        w_push;
    logic [15:0] w_eff_div;
    logic [15:0] w_reload;
    logic [7:0]  w_head;
    logic        w_unused;

    assign w_full     = (r_count == c_depth);
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != c_idle);
    assign w_bit_end  = (r_timer == 16'd0);
    // A byte leaves the FIFO either from IDLE or at the end of a stop bit,
    // so back-to-back frames run without an idle gap.
    assign w_pop      = !w_empty &&
                        ((r_state == c_idle) || ((r_state == c_stop) && w_bit_end));
    assign w_wr       = sel && we;
    assign w_push_req = w_wr && (a[3:2] == 2'd0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_eff_div  = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_reload   = w_eff_div - 16'd1;
    assign w_head     = r_mem[r_rptr];
    assign w_unused   = ^{memsize, a[1:0], wd[31:16]};

    // FIFO pointers, occupancy and control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_div   <= DIV_RESET;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_wr && (a[3:2] == 2'd1))
                r_ovf <= 1'b0;
            else if (w_push_req && !w_push)
                r_ovf <= 1'b1;
            if (w_wr && (a[3:2] == 2'd2))
                r_div <= wd[15:0];
        end
    end

    // FIFO storage carries no reset; contents are only read when count > 0
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wd[7:0];
    end

    // Frame sequencer; the timer holds remaining cycles of the current bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_idle;
            r_timer  <= '0;
            r_bitcnt <= '0;
            r_shreg  <= '0;
`ifdef UART_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else if ((r_state != c_idle) && !w_bit_end) begin
            r_timer <= r_timer - 16'd1;
        end else begin
            case (r_state)
                c_idle, c_stop: begin
                    if (w_pop) begin
                        r_state <= c_start;
                        r_shreg <= w_head;
                        r_timer <= w_reload;
`ifdef UART_TX_PARITY_EN
                        r_par   <= ^w_head;
`endif
                    end else begin
                        r_state <= c_idle;
                    end
                end
                c_start: begin
                    r_state  <= c_data;
                    r_bitcnt <= '0;
                    r_timer  <= w_reload;
                end
                c_data: begin
                    r_timer  <= w_reload;
                    r_shreg  <= {1'b0, r_shreg[7:1]};
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        r_state <= c_parity;
`else
                        r_state <= c_stop;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_parity: begin
                    r_state <= c_stop;
                    r_timer <= w_reload;
                end
`endif
                default: r_state <= c_idle;
            endcase
        end
    end

    // Line driver decoded from state so reset forces the idle level at once
    always_comb begin
        tx = 1'b1;
        case (r_state)
            c_start:  tx = 1'b0;
            c_data:   tx = r_shreg[0];
`ifdef UART_TX_PARITY_EN
            c_parity: tx = r_par;
`endif
            default:  tx = 1'b1;
        endcase
    end

    always_comb begin
        rd = '0;
        if (sel) begin
            case (a[3:2])
                2'd1:    rd = {28'b0, r_ovf, w_busy, w_empty, w_full};
                2'd2:    rd = {16'b0, r_div};
                default: rd = '0;
            endcase
        end
    end

endmodule
`default_nettype wire
